// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Optional subtract mode is enabled with SERIAL_ADD_SUB_EN.
package serial_add_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The sub signal only exists when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(parameter int W = serial_add_pkg::W_DEFAULT);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         busy;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, carry_out, busy
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, result, carry_out, busy
  );

endinterface

// File: rtl/serial_add_ctrl_fa_bit.sv
// Combinational 1-bit full adder cell driven by the serial sequencer.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: accepts two W-bit operands, streams them LSB-first
// through fa_bit, and returns {carry_out, result}. SERIAL_ADD_SUB_EN adds subtract.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// SHIFT | one operand bit through the adder cell per clock, busy high
// DONE  | result presented, waiting for out_ready
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  serial_add_ctrl_if.slave  bus
);

  localparam int CW = cnt_width(W);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fa_sum, fa_co;
  logic [W-1:0]    b_load;
  logic            carry_load;

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: invert B and inject a carry of one.
  assign b_load     = bus.sub ? ~bus.op_b : bus.op_b;
  assign carry_load = bus.sub;
`else
  assign b_load     = bus.op_b;
  assign carry_load = 1'b0;
`endif

  fa_bit u_fa_bit (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .ci  (carry_q),
    .sum (fa_sum),
    .co  (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.op_a;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d        = a_q >> 1;
        b_d        = b_q >> 1;
        res_d      = res_q >> 1;
        res_d[W-1] = fa_sum;
        carry_d    = fa_co;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // All handshake outputs decode from registered state only.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.result    = res_q;
  assign bus.carry_out = carry_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer that feeds a 1-bit full-adder cell and consumes its sum/carry outputs.
- Accepts two W-bit operands over a valid/ready handshake.
- Streams the operands LSB-first through the full-adder cell, one bit per clock, with a registered carry.
- Reassembles the W-bit sum plus carry-out and presents them on an output valid/ready handshake.
- Sits between the operand source (register file / test stimulus) and the result consumer.

Parameters:
- W, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  in  1  rising-edge clock (the block's single clock)
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- op_a  in  W  operand A
- op_b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  W  sum bits [W-1:0]
- carry_out  out  1  final carry (bit W of the sum)
- busy  out  1  high in SHIFT state

Behaviour:
- Reset: asynchronous, active-low.
  - Assertion of rst_n=0 at any time, including mid-operation, immediately forces state=IDLE.
  - Forces in_ready=1, out_valid=0, result=0, carry_out=0, busy=0, bit counter=0, carry register=0.
  - Any operation in flight is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: load shift_a=op_a, shift_b=op_b, carry register=0, count=0, result shift register=0; go to SHIFT. This edge is E0.
- SHIFT:
  - in_ready=0, busy=1.
  - Full-adder cell inputs: a=shift_a[0], b=shift_b[0], ci=carry register.
  - Each edge:
    - Shift shift_a/shift_b right by one.
    - Shift the cell's sum into the result register MSB (result register shifts right).
    - Carry register takes the cell's co.
    - count increments.
  - On the edge where count==W-1, go to DONE. This is edge EW; W bits are processed on edges E1..EW.
- DONE:
  - out_valid=1; result and carry_out are stable and equal the W-bit sum and final carry.
  - in_ready=0.
  - On an edge with out_ready=1: go to IDLE, out_valid drops.
  - result/carry_out hold their last value until the next accept.
- Latency: out_valid rises W cycles after the accepting edge E0. Throughput is one operation per W+2 cycles minimum (accept, W shifts, handshake).
- Arithmetic:
  - {carry_out, result} = op_a + op_b, modulo 2^(W+1).
  - The counter is max(1, $clog2(W)) bits wide.
  - W=1 goes to DONE after a single SHIFT edge.
- Boundary conditions:
  - in_valid while not IDLE is ignored; the source must hold it.
  - out_ready while not DONE has no effect.
  - out_ready held permanently high gives back-to-back operation; no combinational path from out_ready to in_ready.
  - op_a/op_b changes after acceptance have no effect.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled at accept.
  - When sub=1: operand B is bit-inverted at load and the carry register initialises to 1, so result = op_a - op_b modulo 2^W. carry_out=1 means no borrow.
  - When sub=0: behaviour is identical to addition.
- When undefined: no sub port exists; the carry register always initialises to 0.

Decomposition:
- Package serial_add_pkg holds:
  - FSM state encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default W.
- One sub-module, fa_bit (a, b, ci -> sum, co): combinational RTL 1-bit full adder, instantiated once inside serial_add_ctrl.

Test Plan:
1. W=8, op_a=8'h05, op_b=8'h03, out_ready=1 -> out_valid high exactly 8 cycles after accept; result=8'h08, carry_out=0.
2. W=8, op_a=8'hFF, op_b=8'h01 -> result=8'h00, carry_out=1. Then op_a=8'hFF, op_b=8'hFF -> result=8'hFE, carry_out=1.
3. Backpressure: out_ready=0 for 5 cycles after out_valid -> result held, in_ready=0, second in_valid ignored. Release out_ready -> next accept occurs the cycle after IDLE re-entry.
4. Reset mid-SHIFT: drop rst_n after 4 shift cycles -> outputs immediately 0/in_ready=1. After release, op_a=8'h10, op_b=8'h20 -> result=8'h30.
5. W=1: op_a=1, op_b=1 -> result=1'b0, carry_out=1, out_valid 1 cycle after accept.
6. With SERIAL_ADD_SUB_EN: sub=1, op_a=8'h05, op_b=8'h07 -> result=8'hFE, carry_out=0. Then sub=1, op_a=8'h07, op_b=8'h05 -> result=8'h02, carry_out=1.
